lab3_vector_driver: RTL and testbench
=====================================

Name: lab3_vector_driver

Overview:
Self-checking stimulus stage that sits directly upstream of the lab3 complex CMOS gate. It drives all 64 combinations of the gate's inputs A..F, waits a programmable settle time for each, and samples the gate output Y. It compares each sample against the golden function Y = ~((A|B) & ((C&D)|(E&F))) and reports the error count, the first failing vector and a pass/fail flag.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before Y is sampled; legal range is 1..255, and 0 is illegal (elaboration-time check).
ERR_W, 7, width of the error counter; the counter saturates at 2^ERR_W-1.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to run a full sweep; sampled only in IDLE or DONE.
dut_in  output  6  drive to the gate: bit5=A, bit4=B, bit3=C, bit2=D, bit1=E, bit0=F.
dut_y  input  1  gate output Y; treated as synchronous, with no synchroniser.
busy  output  1  high from the cycle after an accepted start until DONE is entered.
done  output  1  high while in DONE; held until the next accepted start or reset.
pass  output  1  valid when done=1; equals 1 iff err_count==0.
err_count  output  ERR_W  number of mismatching vectors; saturating.
first_fail_vec  output  6  dut_in value of the first mismatch.
first_fail_valid  output  1  set on the first mismatch; cleared on start or reset.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, settle counter=0.
- States and transitions:
  - IDLE: on start, go to DRIVE. Also set vec=0 and settle_cnt=0, clear err_count, first_fail_*, and pass.
  - DRIVE: dut_in=vec. Increment settle_cnt each cycle; go to SAMPLE when settle_cnt==SETTLE_CYCLES-1.
  - SAMPLE: compare dut_y with golden(vec). On mismatch, increment err_count (saturating). On the first mismatch, also latch first_fail_vec=vec and set first_fail_valid.
    - If vec==63, go to DONE.
    - Otherwise vec<=vec+1, settle_cnt<=0, and go to DRIVE.
  - DONE: done=1 and pass=(err_count==0). dut_in holds 63. A start here behaves exactly as start in IDLE.
- Timing:
  - dut_in holds each vector for exactly SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE plus the SAMPLE cycle.
  - dut_in changes only on the edge that leaves SAMPLE or IDLE/DONE.
  - A full sweep is 64*(SETTLE_CYCLES+1) cycles from the first DRIVE cycle to the DONE entry edge; this is 192 cycles at default.
- start while busy is ignored and has no side effects.
- err_count saturates: it never wraps, and mismatches beyond the maximum still leave first_fail_* unchanged.
- The vector counter is 6 bits and never wraps during a sweep; the 63 check takes priority over increment.
- rst_n asserted mid-sweep returns all outputs to reset values immediately, with no completion pulse. After release the block waits in IDLE for start.
- dut_y is ignored outside SAMPLE.
- Golden check values: golden is 0 for exactly 21 of the 64 vectors and 1 for 43.
  - First golden-0 vector is 6'b010011 (19).
  - golden(0)=1 and golden(63)=0.

Test Plan:
- Correct DUT (lab3 instance or behavioural model), SETTLE_CYCLES=2, pulse start -> done after 192 cycles, pass=1, err_count=0, first_fail_valid=0.
- dut_y tied 1 -> err_count=21, pass=0, first_fail_vec=6'd19, first_fail_valid=1.
- dut_y tied 0 -> err_count=43, first_fail_vec=6'd0.
- ERR_W=4, dut_y tied 0 -> err_count saturates at 15, first_fail_vec=0, and done still arrives after 192 cycles.
- Timing check, SETTLE_CYCLES=1:
  - start held high throughout the sweep -> run not restarted, busy stays high.
  - Each dut_in value is held exactly 2 cycles; done arrives after 128 cycles.
  - A second start from DONE clears err_count and reruns the sweep.
- rst_n pulsed low at vector 30 -> dut_in=0, busy=0, and err_count=0 asynchronously. A later start runs a clean full sweep with pass=1.

Source files
------------

// File: rtl/lab3_vector_driver_if.sv
// Bus between the lab3 vector driver and the complex-gate under test plus its
// status consumer. The master side is the driver itself.
interface lab3_vector_driver_if #(
  parameter int ERR_W = 7
);
  logic             start;
  logic [5:0]       dut_in;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [5:0]       first_fail_vec;
  logic             first_fail_valid;

  modport master (
    input  start, dut_y,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, dut_y,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/lab3_vector_driver.sv
// Exhaustive stimulus/checker for the lab3 gate Y = ~((A|B) & ((C&D)|(E&F))):
// walks all 64 input codes, settles each, samples Y and tallies mismatches.
module lab3_vector_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lab3_vector_driver_if.master bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must lie in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e           state_q, state_d;
  logic [5:0]       vec_q, vec_d;
  logic [7:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [5:0]       ffv_q, ffv_d;
  logic             ffok_q, ffok_d;

  function automatic logic golden(input logic [5:0] v);
    return ~((v[5] | v[4]) & ((v[3] & v[2]) | (v[1] & v[0])));
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == ERR_MAX) ? c : c + ERR_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffok_d   = ffok_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = DRIVE;
          vec_d    = 6'd0;
          settle_d = 8'd0;
          err_d    = '0;
          ffv_d    = 6'd0;
          ffok_d   = 1'b0;
        end
      end
      DRIVE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (bus.dut_y != golden(vec_q)) begin
          err_d = sat_inc(err_q);
          if (!ffok_q) begin
            ffok_d = 1'b1;
            ffv_d  = vec_q;
          end
        end
        // Last code ends the sweep; the counter is never allowed to wrap to 0.
        if (vec_q == 6'd63) begin
          state_d = DONE;
        end else begin
          vec_d    = vec_q + 6'd1;
          settle_d = 8'd0;
          state_d  = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 6'd0;
      settle_q <= 8'd0;
      err_q    <= '0;
      ffv_q    <= 6'd0;
      ffok_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffok_q   <= ffok_d;
    end
  end

  // vec_q already reads 0 in IDLE and 63 in DONE, so it drives the gate directly.
  assign bus.dut_in           = vec_q;
  assign bus.busy             = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done             = (state_q == DONE);
  assign bus.pass             = (state_q == DONE) && (err_q == '0);
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffok_q;

endmodule

// File: tb/tb_lab3_vector_driver.sv
// Bench for lab3_vector_driver: two instances (settle 2 / 7-bit count and
// settle 1 / 4-bit count) checked every cycle against a sweep-position model.
module tb_lab3_vector_driver;
  localparam int SA = 2;
  localparam int SB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lab3_vector_driver_if #(.ERR_W(7)) ia();
  lab3_vector_driver_if #(.ERR_W(4)) ib();

  lab3_vector_driver #(.SETTLE_CYCLES(SA), .ERR_W(7)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.master));
  lab3_vector_driver #(.SETTLE_CYCLES(SB), .ERR_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.master));

  int n_vec = 0;
  int n_miss = 0;
  int ymode_a = 0;
  int ymode_b = 0;
  logic rnd_a = 1'b0;
  logic rnd_b = 1'b0;

  function automatic bit gold(int v);
    bit a, b, c, d, e, f;
    a = v[5]; b = v[4]; c = v[3]; d = v[2]; e = v[1]; f = v[0];
    return !((a || b) && ((c && d) || (e && f)));
  endfunction

  // 0: behaves like a correct gate, 1: stuck at 1, 2: stuck at 0, 3: random
  assign ia.dut_y = (ymode_a == 0) ? gold(int'(ia.dut_in)) : (ymode_a == 1) ? 1'b1 :
                    (ymode_a == 2) ? 1'b0 : rnd_a;
  assign ib.dut_y = (ymode_b == 0) ? gold(int'(ib.dut_in)) : (ymode_b == 1) ? 1'b1 :
                    (ymode_b == 2) ? 1'b0 : rnd_b;

  always @(posedge clk) begin
    #1;
    rnd_a = 1'($urandom_range(0, 1));
    rnd_b = 1'($urandom_range(0, 1));
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position k counts cycles since the accepted start; vector = k/(s+1),
  // and the last cycle of each vector's slot is the sample cycle.
  typedef struct {
    bit active;
    bit fin;
    int k;
    int err;
    int ffv;
    bit ffok;
  } mdl_t;

  function automatic mdl_t mdl_idle();
    mdl_t r;
    r.active = 0; r.fin = 0; r.k = 0; r.err = 0; r.ffv = 0; r.ffok = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, logic st, logic y, int s);
    mdl_t r;
    int vec;
    r = m;
    vec = m.k / (s + 1);
    if (!m.active) begin
      if (st === 1'b1) begin
        r = mdl_idle();
        r.active = 1;
      end
    end else begin
      if ((m.k % (s + 1)) == s && y !== logic'(gold(vec))) begin
        r.err = m.err + 1;
        if (!m.ffok) begin
          r.ffok = 1;
          r.ffv = vec;
        end
      end
      r.k = m.k + 1;
      if (r.k == 64 * (s + 1)) begin
        r.active = 0;
        r.fin = 1;
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, mdl_t m, int s, int emax, logic [5:0] din, logic busy,
                     logic done, logic pass, logic [31:0] errc, logic [5:0] ffv, logic ffok);
    int e_din;
    e_din = m.active ? m.k / (s + 1) : (m.fin ? 63 : 0);
    cmp({tag, ".dut_in"}, 32'(din), e_din);
    cmp({tag, ".busy"}, 32'(busy), 32'(m.active));
    cmp({tag, ".done"}, 32'(done), 32'(m.fin));
    cmp({tag, ".pass"}, 32'(pass), (m.fin && m.err == 0) ? 1 : 0);
    cmp({tag, ".err_count"}, errc, (m.err > emax) ? emax : m.err);
    cmp({tag, ".first_fail_vec"}, 32'(ffv), m.ffv);
    cmp({tag, ".first_fail_valid"}, 32'(ffok), 32'(m.ffok));
  endtask

  mdl_t ma = mdl_idle();
  mdl_t mb = mdl_idle();

  always @(negedge clk) begin
    if (!rst_n) begin
      ma = mdl_idle();
      mb = mdl_idle();
    end
    chk("a", ma, SA, 127, ia.dut_in, ia.busy, ia.done, ia.pass, 32'(ia.err_count),
        ia.first_fail_vec, ia.first_fail_valid);
    chk("b", mb, SB, 15, ib.dut_in, ib.busy, ib.done, ib.pass, 32'(ib.err_count),
        ib.first_fail_vec, ib.first_fail_valid);
    if (rst_n) begin
      ma = step(ma, ia.start, ia.dut_y, SA);
      mb = step(mb, ib.start, ib.dut_y, SB);
    end
  end

  task automatic run_a(int mode, bit jitter, output int cyc);
    ymode_a = mode;
    @(posedge clk); #1 ia.start = 1'b1;
    @(posedge clk); #1 ia.start = jitter ? 1'($urandom_range(0, 1)) : 1'b0;
    cyc = 0;
    while (ia.done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (jitter) ia.start = 1'($urandom_range(0, 1));
    end
    ia.start = 1'b0;
  endtask

  task automatic run_b(int mode, bit hold, output int cyc);
    ymode_b = mode;
    @(posedge clk); #1 ib.start = 1'b1;
    @(posedge clk); #1 ib.start = hold;
    cyc = 0;
    while (ib.done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ib.start = 1'b0;
  endtask

  initial begin
    int cyc;
    int z;
    int first;
    int pre;
    int n;
    ia.start = 1'b0;
    ib.start = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    z = 0; first = -1;
    for (int v = 0; v < 64; v++) begin
      if (!gold(v)) begin
        z++;
        if (first < 0) first = v;
      end
    end
    cmp("gold_zero_count", z, 21);
    cmp("gold_first_zero", first, 19);
    cmp("gold_0", 32'(gold(0)), 1);
    cmp("gold_63", 32'(gold(63)), 0);

    run_a(0, 0, cyc);
    cmp("a_good_cycles", cyc, 192);
    cmp("a_good_pass", 32'(ia.pass), 1);
    cmp("a_good_err", 32'(ia.err_count), 0);
    cmp("a_good_ffok", 32'(ia.first_fail_valid), 0);

    run_a(1, 0, cyc);
    cmp("a_one_cycles", cyc, 192);
    cmp("a_one_err", 32'(ia.err_count), 21);
    cmp("a_one_pass", 32'(ia.pass), 0);
    cmp("a_one_ffv", 32'(ia.first_fail_vec), 19);
    cmp("a_one_ffok", 32'(ia.first_fail_valid), 1);

    run_a(2, 0, cyc);
    cmp("a_zero_err", 32'(ia.err_count), 43);
    cmp("a_zero_ffv", 32'(ia.first_fail_vec), 0);
    cmp("a_zero_ffok", 32'(ia.first_fail_valid), 1);

    repeat (2) begin
      run_a(3, 1, cyc);
      cmp("a_rand_cycles", cyc, 192);
    end

    run_b(2, 0, cyc);
    cmp("b_sat_cycles", cyc, 128);
    cmp("b_sat_err", 32'(ib.err_count), 15);
    cmp("b_sat_ffv", 32'(ib.first_fail_vec), 0);
    cmp("b_sat_ffok", 32'(ib.first_fail_valid), 1);

    run_b(0, 1, cyc);
    cmp("b_hold_cycles", cyc, 128);
    cmp("b_rerun_err", 32'(ib.err_count), 0);
    cmp("b_rerun_pass", 32'(ib.pass), 1);

    ymode_a = 1;
    @(posedge clk); #1 ia.start = 1'b1;
    @(posedge clk); #1 ia.start = 1'b0;
    n = 0;
    while (ia.dut_in !== 6'd30 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    cmp("a_reach_vec30", 32'(ia.dut_in), 30);
    pre = 0;
    for (int v = 0; v < 30; v++) if (!gold(v)) pre++;
    cmp("a_err_before_rst", 32'(ia.err_count), pre);
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_dut_in", 32'(ia.dut_in), 0);
    cmp("rst_busy", 32'(ia.busy), 0);
    cmp("rst_err", 32'(ia.err_count), 0);
    cmp("rst_done", 32'(ia.done), 0);
    cmp("rst_b_done", 32'(ib.done), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_a(0, 0, cyc);
    cmp("a_after_rst_cycles", cyc, 192);
    cmp("a_after_rst_pass", 32'(ia.pass), 1);
    cmp("a_after_rst_err", 32'(ia.err_count), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
